// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer. The operands pass LSB-first through one
// shared full adder. The carry is held in a flop between bits, and the result
// is assembled in a right-shifting register. Results appear WIDTH cycles after
// the accepting edge and stay on the outputs until the next operation finishes.

module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b ^ i_c;
    assign o_c = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_sub,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_ready,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry,
    output logic             o_overflow
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             fa_s;
    logic             fa_co;
    logic [WIDTH:0]   res_ext_s;

    // The only adder in the block: current LSBs plus the stored carry.
    full_adder u_fa (
        .i_a (sa_q[0]),
        .i_b (sb_q[0]),
        .i_c (carry_q),
        .o_s (fa_s),
        .o_c (fa_co)
    );

    // The new sum bit enters at the MSB. The extra bit keeps the slice legal when WIDTH=1.
    assign res_ext_s = {fa_s, res_q};

    // Next-state and datapath logic for the IDLE/RUN/DONE sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
                    sa_d    = i_a;
                    sb_d    = i_sub ? ~i_b : i_b;
                    carry_d = i_sub;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                sa_d    = sa_q >> 1;
                sb_d    = sb_q >> 1;
                res_d   = res_ext_s[WIDTH:1];
                carry_d = fa_co;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    // carry_q is the carry into the MSB and fa_co is the carry out of it.
                    sum_d   = res_ext_s[WIDTH:1];
                    cout_d  = fa_co;
                    ovf_d   = carry_q ^ fa_co;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d == ST_RUN);
        done_d  = (state_d == ST_DONE);
    end

    // All state and registered outputs. Reset aborts any operation in progress.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sa_q    <= '0;
            sb_q    <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o_ready    = ready_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_sum      = sum_q;
    assign o_carry    = cout_q;
    assign o_overflow = ovf_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl. A scoreboard queue is filled on
// accepted starts and drained on the final RUN edge. A WIDTH=1 instance covers
// the single-bit corner case.

module tb_serial_adder_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start, sub;
    logic [W-1:0] a, b;
    logic         ready, busy, done, carry, ovf;
    logic [W-1:0] sum;

    logic         s1_start, s1_sub;
    logic [0:0]   s1_a, s1_b, s1_sum;
    logic         s1_ready, s1_busy, s1_done, s1_carry, s1_ovf;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         carry;
        logic         ovf;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   m_state  = 0;
    int   m_cnt    = 0;
    int   m_dones  = 0;
    int   m_miss   = 0;
    int   n_dut_done = 0;
    exp_t m_out    = '0;
    logic chk_en   = 1'b0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_sub(sub),
        .i_a(a), .i_b(b), .o_ready(ready), .o_busy(busy), .o_done(done),
        .o_sum(sum), .o_carry(carry), .o_overflow(ovf)
    );

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(s1_start), .i_sub(s1_sub),
        .i_a(s1_a), .i_b(s1_b), .o_ready(s1_ready), .o_busy(s1_busy), .o_done(s1_done),
        .o_sum(s1_sum), .o_carry(s1_carry), .o_overflow(s1_ovf)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference arithmetic; overflow is derived from operand and result signs.
    function automatic exp_t model_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        logic [W:0] full;
        exp_t       r;
        full    = {1'b0, x} + {1'b0, (s ? ~y : y)} + {{W{1'b0}}, s};
        r.sum   = full[W-1:0];
        r.carry = full[W];
        if (s) r.ovf = (x[W-1] != y[W-1]) && (r.sum[W-1] != x[W-1]);
        else   r.ovf = (x[W-1] == y[W-1]) && (r.sum[W-1] != x[W-1]);
        return r;
    endfunction

    // Cycle model of the sequencer: push on accept, pop on the final RUN edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state <= 0;
            m_cnt   <= 0;
            m_out   <= '0;
            sb_q.delete();
        end else begin
            case (m_state)
                0: if (start) begin
                    sb_q.push_back(model_op(a, b, sub));
                    m_state <= 1;
                    m_cnt   <= 0;
                end
                1: if (m_cnt == W - 1) begin
                    if (sb_q.size() > 0) m_out <= sb_q.pop_front();
                    else m_miss <= m_miss + 1;
                    m_dones <= m_dones + 1;
                    m_state <= 2;
                end else begin
                    m_cnt <= m_cnt + 1;
                end
                default: m_state <= 0;
            endcase
        end
    end

    // Compare every output against the model each cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            check_eq("ready", 32'(ready), 32'(m_state == 0));
            check_eq("busy",  32'(busy),  32'(m_state == 1));
            check_eq("done",  32'(done),  32'(m_state == 2));
            check_eq("sum",   32'(sum),   32'(m_out.sum));
            check_eq("carry", 32'(carry), 32'(m_out.carry));
            check_eq("ovf",   32'(ovf),   32'(m_out.ovf));
            if (done) n_dut_done++;
        end
    end

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        @(negedge clk);
        start = 1'b1; a = x; b = y; sub = s;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom;
        repeat (W + 2) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ready"}, 32'(ready), 32'd1);
        check_eq({tag, "_busy"},  32'(busy),  32'd0);
        check_eq({tag, "_done"},  32'(done),  32'd0);
        check_eq({tag, "_sum"},   32'(sum),   32'd0);
        check_eq({tag, "_carry"}, 32'(carry), 32'd0);
        check_eq({tag, "_ovf"},   32'(ovf),   32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        s1_start = 1'b0; s1_sub = 1'b0; s1_a = 1'b0; s1_b = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        check_eq("rst_w1_ready", 32'(s1_ready), 32'd1);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Directed operations from the arithmetic corner cases.
        run_op(8'h3C, 8'h45, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0);
        run_op(8'h7F, 8'h01, 1'b0);
        run_op(8'h05, 8'h07, 1'b1);
        run_op(8'h80, 8'h01, 1'b1);

        // i_start held high with changing operands: only IDLE-edge operands count.
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 45; i++) begin
            a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        start = 1'b0;
        repeat (W + 3) @(negedge clk);

        // Abort in the fourth RUN cycle, then a clean operation.
        @(negedge clk);
        start = 1'b1; a = 8'h55; b = 8'h11; sub = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("abort");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_op(8'h12, 8'h34, 1'b0);

        // WIDTH=1 instance: 1+1 gives sum 0, carry 1, overflow 1.
        @(negedge clk);
        s1_start = 1'b1; s1_a = 1'b1; s1_b = 1'b1; s1_sub = 1'b0;
        @(negedge clk);
        s1_start = 1'b0;
        check_eq("w1_busy", 32'(s1_busy), 32'd1);
        check_eq("w1_done_early", 32'(s1_done), 32'd0);
        @(negedge clk);
        check_eq("w1_done",  32'(s1_done),  32'd1);
        check_eq("w1_sum",   32'(s1_sum),   32'd0);
        check_eq("w1_carry", 32'(s1_carry), 32'd1);
        check_eq("w1_ovf",   32'(s1_ovf),   32'd1);
        @(negedge clk);
        check_eq("w1_done_clr", 32'(s1_done),  32'd0);
        check_eq("w1_ready",    32'(s1_ready), 32'd1);
        check_eq("w1_hold_carry", 32'(s1_carry), 32'd1);

        check_eq("done_count", 32'(n_dut_done), 32'(m_dones));
        check_eq("queue_miss", 32'(m_miss), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
